// File: rtl/pipe_perf_trace.sv
// Pipeline performance tracer: counts cycles, stalls, flushes and retires, and streams a frozen 5-word snapshot.
// Optional macro PERF_SATURATE_EN makes the counters saturate and flags saturation in bit 31 of word 0.
module pipe_perf_trace #(
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 64,
    parameter int NUM_WORDS  = 5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic        flush_i,
    input  logic        retire_i,
    input  logic [31:0] pc_i,
    input  logic        snap_req_i,
    output logic        busy_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic        out_last_o,
    output logic        halt_o
);

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [2:0]       LAST_IDX = 3'(NUM_WORDS - 1);
    localparam bit               HALT_EN  = (MAX_CYCLES != 0);
    localparam logic [31:0]      HALT_AT  = 32'(MAX_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       wordIdx_q, wordIdx_d;
    logic [CNT_W-1:0] cycCnt_q, cycCnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;
    logic [CNT_W-1:0] retCnt_q, retCnt_d;
    logic             halt_q, halt_d;
    logic [31:0]      shadow_q [NUM_WORDS];
    logic [31:0]      shadow_d [NUM_WORDS];
    logic [31:0]      snapWord0;
    logic             countEn;
    logic             captureEn;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic hit);
`ifdef PERF_SATURATE_EN
        bump = (hit && (v != CNT_MAX)) ? v + CNT_W'(1) : v;
`else
        bump = hit ? v + CNT_W'(1) : v;
`endif
    endfunction

    assign countEn   = start_i && !halt_q;
    assign captureEn = (state_q == IDLE) && snap_req_i;

`ifdef PERF_SATURATE_EN
    localparam bit SAT_REPORT = (CNT_W <= 31);
    logic satFlag_q, satFlag_d;

    // Sticky once any counter has pinned at its maximum; only reportable when bit 31 is free.
    always_comb begin
        satFlag_d = satFlag_q || (cycCnt_d == CNT_MAX) || (stallCnt_d == CNT_MAX)
                    || (flushCnt_d == CNT_MAX) || (retCnt_d == CNT_MAX);
        snapWord0 = 32'(cycCnt_q) | {(SAT_REPORT && satFlag_q), 31'd0};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            satFlag_q <= 1'b0;
        end else begin
            satFlag_q <= satFlag_d;
        end
    end
`else
    assign snapWord0 = 32'(cycCnt_q);
`endif

    // Event counters, halt budget and snapshot capture of pre-edge counter values.
    always_comb begin
        cycCnt_d   = bump(cycCnt_q, countEn);
        stallCnt_d = bump(stallCnt_q, countEn && stall_i && !branch_i);
        flushCnt_d = bump(flushCnt_q, countEn && flush_i);
        retCnt_d   = bump(retCnt_q, countEn && retire_i);
        halt_d     = halt_q || (HALT_EN && countEn && (32'(cycCnt_q) == HALT_AT));
        shadow_d   = shadow_q;
        if (captureEn) begin
            shadow_d[0] = snapWord0;
            shadow_d[1] = 32'(stallCnt_q);
            shadow_d[2] = 32'(flushCnt_q);
            shadow_d[3] = 32'(retCnt_q);
            shadow_d[4] = pc_i;
        end
    end

    always_comb begin
        state_d   = state_q;
        wordIdx_d = wordIdx_q;
        case (state_q)
            IDLE: begin
                if (snap_req_i) begin
                    state_d   = SEND;
                    wordIdx_d = 3'd0;
                end
            end
            SEND: begin
                if (out_ready_i) begin
                    if (wordIdx_q == LAST_IDX) begin
                        state_d   = IDLE;
                        wordIdx_d = 3'd0;
                    end else begin
                        wordIdx_d = wordIdx_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                wordIdx_d = 3'd0;
            end
        endcase
    end

    always_comb begin
        busy_o      = (state_q == SEND);
        out_valid_o = (state_q == SEND);
        out_last_o  = (state_q == SEND) && (wordIdx_q == LAST_IDX);
        out_data_o  = (state_q == SEND) ? shadow_q[wordIdx_q] : 32'd0;
        halt_o      = halt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            wordIdx_q  <= 3'd0;
            cycCnt_q   <= '0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
            retCnt_q   <= '0;
            halt_q     <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                shadow_q[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            wordIdx_q  <= wordIdx_d;
            cycCnt_q   <= cycCnt_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
            retCnt_q   <= retCnt_d;
            halt_q     <= halt_d;
            shadow_q   <= shadow_d;
        end
    end

endmodule

// File: tb/tb_pipe_perf_trace.sv
// Self-checking bench for pipe_perf_trace: vector table plus scoreboard of expected snapshot words.
// A second CNT_W=4 instance covers wrap versus PERF_SATURATE_EN saturation.
module tb_pipe_perf_trace;

    localparam int MAXC = 64;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        retire_i = 1'b0;
    logic [31:0] pc_i = 32'd0;
    logic        snap_req_i = 1'b0;
    logic        out_ready_i = 1'b1;
    logic        busy_o, out_valid_o, out_last_o, halt_o;
    logic [31:0] out_data_o;

    logic        start4 = 1'b0;
    logic        snap4 = 1'b0;
    logic        busy4, valid4, last4, halt4;
    logic [31:0] data4;

    always #5 clk_i = ~clk_i;

    pipe_perf_trace #(.CNT_W(32), .MAX_CYCLES(MAXC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .branch_i(branch_i), .flush_i(flush_i), .retire_i(retire_i), .pc_i(pc_i),
        .snap_req_i(snap_req_i), .busy_o(busy_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_data_o(out_data_o), .out_last_o(out_last_o),
        .halt_o(halt_o)
    );

    pipe_perf_trace #(.CNT_W(4), .MAX_CYCLES(0)) dut4 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start4), .stall_i(1'b0),
        .branch_i(1'b0), .flush_i(1'b0), .retire_i(1'b0), .pc_i(pc_i),
        .snap_req_i(snap4), .busy_o(busy4), .out_valid_o(valid4),
        .out_ready_i(1'b1), .out_data_o(data4), .out_last_o(last4),
        .halt_o(halt4)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
    } word_t;

    typedef struct {
        logic        stall;
        logic        branch;
        logic        flush;
        logic        retire;
        logic [31:0] expCyc;
        logic [31:0] expStall;
        logic [31:0] expFlush;
        logic [31:0] expRet;
    } vec_t;

    word_t       expQ[$];
    vec_t        vecs[10];
    int          checks = 0;
    int          errors = 0;
    int unsigned mCyc, mStall, mFlush, mRet;
    bit          mHalt;
    int          busyCycles;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic pushFrame(input logic [31:0] c, input logic [31:0] s, input logic [31:0] f,
                             input logic [31:0] r, input logic [31:0] pc);
        expQ.push_back('{c, 1'b0});
        expQ.push_back('{s, 1'b0});
        expQ.push_back('{f, 1'b0});
        expQ.push_back('{r, 1'b0});
        expQ.push_back('{pc, 1'b1});
    endtask

    // Advance one clock; the reference counts follow the inputs held across that edge.
    task automatic tick();
        @(posedge clk_i);
        if (rst_i) begin
            mCyc = 0; mStall = 0; mFlush = 0; mRet = 0; mHalt = 0;
        end else if (start_i && !mHalt) begin
            mCyc++;
            if (stall_i && !branch_i) mStall++;
            if (flush_i) mFlush++;
            if (retire_i) mRet++;
            if (mCyc == MAXC) mHalt = 1;
        end
        #1;
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        expQ.delete();
    endtask

    task automatic waitFrameDone(output int nBusy);
        int n;
        n = 0;
        nBusy = 0;
        while (n < 40 && (busy_o || expQ.size() != 0)) begin
            if (busy_o) nBusy++;
            tick();
            n++;
        end
        checks++;
        if (busy_o || expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL frameTimeout busy=%0b pending=%0d required busy=0 pending=0", busy_o, expQ.size());
            expQ.delete();
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        start_i  = 1'b1;
        stall_i  = v.stall;
        branch_i = v.branch;
        flush_i  = v.flush;
        retire_i = v.retire;
        tick();
        start_i  = 1'b0;
        stall_i  = 1'b0;
        branch_i = 1'b0;
        flush_i  = 1'b0;
        retire_i = 1'b0;
    endtask

    // Scoreboard: every accepted word is compared against the head of the expected queue.
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWord actual=%h required=no word", out_data_o);
            end else begin
                word_t w;
                w = expQ.pop_front();
                checkOutput("frameData", out_data_o, w.data);
                checkOutput("frameLast", {31'd0, out_last_o}, {31'd0, w.last});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd1,  32'd1, 32'd0, 32'd1};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'd2,  32'd1, 32'd1, 32'd2};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd3,  32'd1, 32'd1, 32'd3};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd4,  32'd1, 32'd1, 32'd4};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'd5,  32'd2, 32'd2, 32'd5};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd6,  32'd2, 32'd2, 32'd6};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'd7,  32'd2, 32'd2, 32'd7};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd8,  32'd2, 32'd2, 32'd7};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd9,  32'd2, 32'd2, 32'd7};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'd10, 32'd2, 32'd2, 32'd7};

        rst_i = 1'b1;
        tick();
        tick();
        checkOutput("rstBusy", {31'd0, busy_o}, 32'd0);
        checkOutput("rstValid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("rstLast", {31'd0, out_last_o}, 32'd0);
        checkOutput("rstHalt", {31'd0, halt_o}, 32'd0);
        checkOutput("rstData", out_data_o, 32'd0);
        rst_i = 1'b0;
        expQ.delete();

        $display("[TB] narrow counter wrap/saturate");
        start4 = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        start4 = 1'b0;
        snap4 = 1'b1;
        tick();
        snap4 = 1'b0;
        checkOutput("narrowValid", {31'd0, valid4}, 32'd1);
`ifdef PERF_SATURATE_EN
        checkOutput("narrowWord0", data4, 32'h8000_000F);
`else
        checkOutput("narrowWord0", data4, 32'd4);
`endif
        for (int i = 0; i < 6; i++) tick();
        checkOutput("narrowIdle", {31'd0, busy4}, 32'd0);

        $display("[TB] event vector table");
        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v]);
            pc_i = 32'h0000_1000 + 32'(v * 4);
            pushFrame(vecs[v].expCyc, vecs[v].expStall, vecs[v].expFlush, vecs[v].expRet, pc_i);
            snap_req_i = 1'b1;
            tick();
            snap_req_i = 1'b0;
            waitFrameDone(busyCycles);
            if (v == 9) checkOutput("busyCycles", 32'(busyCycles), 32'd5);
        end

        $display("[TB] backpressure hold");
        out_ready_i = 1'b0;
        pc_i = 32'hABCD_0000;
        pushFrame(32'd10, 32'd2, 32'd2, 32'd7, 32'hABCD_0000);
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        pc_i = 32'h0000_1111;
        out_ready_i = 1'b1;
        tick();
        tick();
        out_ready_i = 1'b0;
        start_i = 1'b1;
        retire_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("holdFlush", out_data_o, 32'd2);
            checkOutput("holdValid", {31'd0, out_valid_o}, 32'd1);
        end
        start_i = 1'b0;
        retire_i = 1'b0;
        out_ready_i = 1'b1;
        waitFrameDone(busyCycles);
        pc_i = 32'h0000_2000;
        pushFrame(32'd14, 32'd2, 32'd2, 32'd11, 32'h0000_2000);
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        waitFrameDone(busyCycles);

        $display("[TB] requests during a frame");
        pc_i = 32'h0000_3000;
        pushFrame(32'd14, 32'd2, 32'd2, 32'd11, 32'h0000_3000);
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        tick();
        tick();
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        tick();
        checkOutput("lastFlag", {31'd0, out_last_o}, 32'd1);
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput("droppedBusy", {31'd0, busy_o}, 32'd0);
            checkOutput("droppedValid", {31'd0, out_valid_o}, 32'd0);
            tick();
        end
        checkOutput("droppedPending", 32'(expQ.size()), 32'd0);

        $display("[TB] cycle budget halt");
        doReset();
        start_i = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            checkOutput("haltTrack", {31'd0, halt_o}, {31'd0, mHalt});
        end
        start_i = 1'b0;
        pc_i = 32'h0000_4000;
        pushFrame(32'd64, 32'd0, 32'd0, 32'd0, 32'h0000_4000);
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        waitFrameDone(busyCycles);
        checkOutput("haltSticky", {31'd0, halt_o}, 32'd1);
        doReset();
        checkOutput("haltCleared", {31'd0, halt_o}, 32'd0);

        $display("[TB] reset mid-frame");
        start_i = 1'b1;
        retire_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        start_i = 1'b0;
        retire_i = 1'b0;
        out_ready_i = 1'b0;
        pc_i = 32'h0000_5000;
        pushFrame(32'd3, 32'd0, 32'd0, 32'd3, 32'h0000_5000);
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        out_ready_i = 1'b1;
        tick();
        tick();
        tick();
        out_ready_i = 1'b0;
        checkOutput("preResetWord3", out_data_o, 32'd3);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        expQ.delete();
        checkOutput("abortValid", {31'd0, out_valid_o}, 32'd0);
        checkOutput("abortBusy", {31'd0, busy_o}, 32'd0);
        checkOutput("abortData", out_data_o, 32'd0);
        out_ready_i = 1'b1;
        pc_i = 32'h0000_6000;
        pushFrame(32'd0, 32'd0, 32'd0, 32'd0, 32'h0000_6000);
        snap_req_i = 1'b1;
        tick();
        snap_req_i = 1'b0;
        waitFrameDone(busyCycles);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
